// File: rtl/xor_gate.sv
// xor_gate: bitwise XOR of two equal-width buses with a zero-latency result,
// a registered copy, a running XOR accumulator and a registered count of
// differing bits. Doubles as a cheap mismatch/parity monitor.
module xor_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             any_diff
);

  // Raw difference vector shared by every output path
  logic [WIDTH-1:0] diff_c;

  logic [WIDTH-1:0] yreg_d, yreg_q;
  logic [WIDTH-1:0] acc_d,  acc_q;
  logic [CNT_W-1:0] cnt_d,  cnt_q;
  logic             any_d,  any_q;

  assign diff_c = a ^ b;

  // Combinational output has no clock or reset dependence
  assign y = diff_c;

  // Registered copy, popcount and OR-reduction load only when enabled
  always_comb begin
    yreg_d = yreg_q;
    cnt_d  = cnt_q;
    any_d  = any_q;
    if (en) begin
      yreg_d = diff_c;
      any_d  = |diff_c;
      cnt_d  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_d = cnt_d + CNT_W'(diff_c[i]);
      end
    end
  end

  // Accumulator: clear has priority over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ diff_c;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yreg_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      yreg_q <= yreg_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      any_q  <= any_d;
    end
  end

  assign y_q      = yreg_q;
  assign acc      = acc_q;
  assign diff_cnt = cnt_q;
  assign any_diff = any_q;

endmodule

// File: tb/tb_xor_gate.sv
// Directed bench for xor_gate: a 1-bit instance for the truth table and an
// 8-bit instance for the registered, accumulator and reset behaviour.
module tb_xor_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] a8 = '0, b8 = '0;
  logic       en8 = 1'b0, clr8 = 1'b0;
  logic [7:0] y8, yq8, acc8;
  logic [6:0] cnt8;
  logic       any8;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       en1 = 1'b0, clr1 = 1'b0;
  logic       y1, yq1, acc1, any1;
  logic [6:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(8), .CNT_W(7)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en8), .clr(clr8),
    .y(y8), .y_q(yq8), .acc(acc8), .diff_cnt(cnt8), .any_diff(any8)
  );

  xor_gate #(.WIDTH(1), .CNT_W(7)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en1), .clr(clr1),
    .y(y1), .y_q(yq1), .acc(acc1), .diff_cnt(cnt1), .any_diff(any1)
  );

  task automatic test_reset();
    #1;
    checks++; if (yq8 !== 8'h00)  begin errors++; $display("FAIL reset_y_q got=%h exp=00", yq8); end
    checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL reset_acc got=%h exp=00", acc8); end
    checks++; if (cnt8 !== 7'd0)  begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    checks++; if (any8 !== 1'b0)  begin errors++; $display("FAIL reset_any got=%b exp=0", any8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] vec [4];
    logic       exp [4];
    vec[0] = 2'b00; exp[0] = 1'b0;
    vec[1] = 2'b01; exp[1] = 1'b1;
    vec[2] = 2'b10; exp[2] = 1'b1;
    vec[3] = 2'b11; exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = vec[i][1];
      b1 = vec[i][0];
      #1;
      checks++;
      if (y1 !== exp[i]) begin
        errors++; $display("FAIL truth_%0d got=%b exp=%b", i, y1, exp[i]);
      end
      #9;
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C; en8 = 1'b1; clr8 = 1'b0;
    #1;
    checks++; if (y8 !== 8'hCC) begin errors++; $display("FAIL basic_y got=%h exp=CC", y8); end
    @(posedge clk); #1;
    checks++; if (yq8 !== 8'hCC) begin errors++; $display("FAIL basic_y_q got=%h exp=CC", yq8); end
    checks++; if (cnt8 !== 7'd4) begin errors++; $display("FAIL basic_cnt got=%0d exp=4", cnt8); end
    checks++; if (any8 !== 1'b1) begin errors++; $display("FAIL basic_any got=%b exp=1", any8); end
    checks++; if (acc8 !== 8'hCC) begin errors++; $display("FAIL basic_acc got=%h exp=CC", acc8); end
  endtask

  task automatic test_accumulate();
    logic [7:0] av [3];
    av[0] = 8'h01; av[1] = 8'h02; av[2] = 8'h01;
    @(negedge clk);
    clr8 = 1'b1; en8 = 1'b0;
    @(negedge clk);
    checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL clr_only_acc got=%h exp=00", acc8); end
    checks++; if (yq8 !== 8'hCC)  begin errors++; $display("FAIL clr_only_y_q got=%h exp=CC", yq8); end
    clr8 = 1'b0; en8 = 1'b1; b8 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      a8 = av[i];
      @(negedge clk);
    end
    checks++; if (acc8 !== 8'h02) begin errors++; $display("FAIL accum_acc got=%h exp=02", acc8); end
    a8 = 8'h01; b8 = 8'h00; clr8 = 1'b1; en8 = 1'b1;
    @(negedge clk);
    checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL clr_en_acc got=%h exp=00", acc8); end
    checks++; if (yq8 !== 8'h01)  begin errors++; $display("FAIL clr_en_y_q got=%h exp=01", yq8); end
    checks++; if (cnt8 !== 7'd1)  begin errors++; $display("FAIL clr_en_cnt got=%0d exp=1", cnt8); end
    clr8 = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C; en8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; en8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (yq8 !== 8'hCC) begin errors++; $display("FAIL hold_y_q got=%h exp=CC", yq8); end
    checks++; if (cnt8 !== 7'd4) begin errors++; $display("FAIL hold_cnt got=%0d exp=4", cnt8); end
    checks++; if (any8 !== 1'b1) begin errors++; $display("FAIL hold_any got=%b exp=1", any8); end
    checks++; if (y8 !== 8'hFF)  begin errors++; $display("FAIL hold_y got=%h exp=FF", y8); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clr8 = 1'b1; en8 = 1'b0;
    @(negedge clk);
    clr8 = 1'b0; en8 = 1'b1; a8 = 8'h5A; b8 = 8'h00;
    @(posedge clk); #1;
    checks++; if (acc8 !== 8'h5A) begin errors++; $display("FAIL pre_rst_acc got=%h exp=5A", acc8); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL async_acc got=%h exp=00", acc8); end
    checks++; if (yq8 !== 8'h00)  begin errors++; $display("FAIL async_y_q got=%h exp=00", yq8); end
    checks++; if (cnt8 !== 7'd0)  begin errors++; $display("FAIL async_cnt got=%0d exp=0", cnt8); end
    checks++; if (any8 !== 1'b0)  begin errors++; $display("FAIL async_any got=%b exp=0", any8); end
    a8 = 8'h77; b8 = 8'h70;
    #1;
    checks++; if (y8 !== 8'h07) begin errors++; $display("FAIL rst_y_track got=%h exp=07", y8); end
    @(posedge clk); #1;
    checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL rst_hold_y_q got=%h exp=00", yq8); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (yq8 !== 8'h07) begin errors++; $display("FAIL post_rst_y_q got=%h exp=07", yq8); end
    checks++; if (acc8 !== 8'h07) begin errors++; $display("FAIL post_rst_acc got=%h exp=07", acc8); end
  endtask

  task automatic test_equal_operands();
    a8 = 8'hA5; b8 = 8'hA5; en8 = 1'b1; clr8 = 1'b0;
    #1;
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL eq_y got=%h exp=00", y8); end
    @(negedge clk);
    checks++; if (yq8 !== 8'h00)  begin errors++; $display("FAIL eq_y_q got=%h exp=00", yq8); end
    checks++; if (cnt8 !== 7'd0)  begin errors++; $display("FAIL eq_cnt got=%0d exp=0", cnt8); end
    checks++; if (any8 !== 1'b0)  begin errors++; $display("FAIL eq_any got=%b exp=0", any8); end
    checks++; if (acc8 !== 8'h07) begin errors++; $display("FAIL eq_acc got=%h exp=07", acc8); end
  endtask

  task automatic test_full_width();
    a8 = 8'hFF; b8 = 8'h00; en8 = 1'b1;
    @(negedge clk);
    checks++; if (cnt8 !== 7'd8)  begin errors++; $display("FAIL full_cnt got=%0d exp=8", cnt8); end
    checks++; if (acc8 !== 8'hF8) begin errors++; $display("FAIL full_acc got=%h exp=F8", acc8); end
    a8 = 8'h80; b8 = 8'h00;
    @(negedge clk);
    checks++; if (cnt8 !== 7'd1) begin errors++; $display("FAIL msb_cnt got=%0d exp=1", cnt8); end
    checks++; if (any8 !== 1'b1) begin errors++; $display("FAIL msb_any got=%b exp=1", any8); end
    en8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_basic();
    test_accumulate();
    test_hold();
    test_async_reset();
    test_equal_operands();
    test_full_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_gate.md
Name: xor_gate

Overview:
- Bitwise XOR comparator between two operand vectors.
- Provides a zero-latency combinational result, a registered copy, a running XOR accumulator (parity/checksum) and a registered population count of differing bits.
- Used as a basic logic primitive and as a lightweight mismatch/parity monitor between two equal-width buses.

Parameters:
- WIDTH, 1, bit width of operands a, b and all XOR result outputs; legal range 1..64.
- CNT_W, 7, width of popcount output diff_cnt; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  accumulate/register enable.
- clr  input  1  synchronous clear of acc (and only acc).
- y  output  WIDTH  combinational a XOR b.
- y_q  output  WIDTH  registered a XOR b.
- acc  output  WIDTH  running XOR accumulator.
- diff_cnt  output  CNT_W  registered number of 1 bits in a XOR b.
- any_diff  output  1  registered OR-reduction of a XOR b.

Behaviour:
- y:
  - purely combinational, y = a ^ b per bit, no clock or reset dependence.
  - With WIDTH=1: 0,0->0; 0,1->1; 1,0->1; 1,1->0.
  - Must settle within the same time step as input changes.
  - X/Z on an input bit propagates X to that y bit only.
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk): y_q=0, acc=0, diff_cnt=0, any_diff=0. y is unaffected by reset.
- On each rising clk edge with rst=0:
  - if en=1: y_q <= a^b, diff_cnt <= popcount(a^b), any_diff <= |(a^b).
  - if en=0: y_q, diff_cnt and any_diff hold their values.
  - Latency for these registered outputs: 1 cycle from the sampled inputs.
- acc update priority at each edge (rst=0):
  - clr=1: acc <= 0. Clear wins over en.
  - else if en=1: acc <= acc ^ a ^ b.
  - else: acc holds.
- Simultaneous clr=1 and en=1: acc becomes 0. y_q, diff_cnt and any_diff still update because en=1.
- Reset asserted mid-operation clears the registered outputs immediately. Deassertion takes effect at the next rising edge; no synchronizer is required inside the block.
- diff_cnt range is 0..WIDTH and never wraps, given the CNT_W constraint.
- No internal state other than y_q, acc, diff_cnt and any_diff.

Test Plan:
- WIDTH=1, rst=0. Apply a,b = 00, 01, 10, 11 at 10-time-unit intervals -> y = 0, 1, 1, 0, each valid before the next change.
- WIDTH=8, en=1, a=8'hF0, b=8'h3C, one clk edge -> y=8'hCC immediately; after the edge y_q=8'hCC, diff_cnt=4, any_diff=1.
- WIDTH=8, en=1, three edges with (a,b) = (8'h01,8'h00), (8'h02,8'h00), (8'h01,8'h00) -> acc=8'h02. Then clr=1 and en=1 for one edge -> acc=8'h00 and y_q=8'h01.
- WIDTH=8, y_q=8'hCC, then en=0 with a=8'hFF, b=8'h00 over 3 edges -> y_q stays 8'hCC, diff_cnt stays 4, y=8'hFF.
- Assert rst between clk edges while acc=8'h5A -> acc, y_q, diff_cnt and any_diff become 0 without waiting for an edge; y keeps tracking a^b.
- WIDTH=8, a=b=8'hA5, en=1, one edge -> y=0, y_q=0, diff_cnt=0, any_diff=0, acc unchanged.
